// File: rtl/enc16to4.sv
// Sequential 16-to-4 round-robin encoder: collects request lines into a pending
// register and issues one line index per cycle on a registered valid/ready output.
module enc16to4 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        clr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic        out_multi,
  output logic [15:0] pending
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  idx_q, idx_d;
  logic        multi_q, multi_d;
  logic [3:0]  ptr_q, ptr_d;

  logic [31:0] dbl;
  logic [15:0] rot;
  logic [3:0]  off;
  logic [3:0]  sel;
  logic        found;
  logic        any;
  logic        many;
  logic        load;
  logic [15:0] load_mask;

  // Rotate pending so bit 0 is the pointer position; the first set bit is the winner.
  always_comb begin
    dbl   = {pending_q, pending_q} >> ptr_q;
    rot   = dbl[15:0];
    off   = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = 4'(i);
      end
    end
    sel = ptr_q + off;
  end

  assign any       = |pending_q;
  assign many      = |(pending_q & (pending_q - 16'd1));
  assign load      = any && ((state_q == StEmpty) || out_ready) && !clr;
  assign load_mask = load ? (16'd1 << sel) : 16'd0;

  always_comb begin
    state_d   = state_q;
    pending_d = (pending_q & ~load_mask) | req;
    idx_d     = idx_q;
    multi_d   = multi_q;
    ptr_d     = ptr_q;
    if (clr) begin
      pending_d = req;
      state_d   = StEmpty;
    end else if (load) begin
      state_d = StFull;
      idx_d   = sel;
      multi_d = many;
      ptr_d   = sel + 4'd1;
    end else if ((state_q == StFull) && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      pending_q <= 16'd0;
      idx_q     <= 4'd0;
      multi_q   <= 1'b0;
      ptr_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      multi_q   <= multi_d;
      ptr_q     <= ptr_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_idx   = idx_q;
  assign out_multi = multi_q;
  assign pending   = pending_q;

endmodule

// File: doc/enc16to4.md
# enc16to4

Sequential 16-to-4 round-robin encoder, the counterpart to the instruction-memory 4-to-16 decoder. It collects 16 request lines into a pending register and issues each pending line as a 4-bit index on a valid/ready output. Fairness is round-robin. One index is issued per cycle under no backpressure. It sits between the per-line request/completion sources and any consumer that wants the 4-bit line number back, for example a refill or writeback sequencer.

## Interface
- Parameters: none. Widths are fixed at 16 request lines and a 4-bit index.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- req  in  16  request lines; each high bit sets the matching pending bit at the next edge.
- clr  in  1  synchronous flush of pending bits and output stage.
- out_ready  in  1  consumer accepts `out_idx` when high together with `out_valid`.
- out_valid  out  1  `out_idx` is valid.
- out_idx  out  4  encoded line number.
- out_multi  out  1  at load time, at least one other line remained pending.
- pending  out  16  bits waiting, not yet loaded into the output stage.

## Operation
- Registers:
  - `pending[15:0]`.
  - Output stage: `out_valid`, `out_idx`, `out_multi`.
  - Round-robin pointer `ptr[3:0]`.
- Reset values: `pending`=0, `out_valid`=0, `out_idx`=0, `out_multi`=0, `ptr`=0.
- Output stage FSM:
  - EMPTY (`out_valid`=0): if `pending`≠0, load and go to FULL.
  - FULL (`out_valid`=1):
    - If `out_ready`=0, hold; `out_idx` and `out_multi` stay stable.
    - If `out_ready`=1 (handshake) and `pending`≠0, load again and stay FULL.
    - If `out_ready`=1 and `pending`=0, go to EMPTY.
- load = (`pending`≠0) and (!`out_valid` or `out_ready`) and !`clr`.
- Selection:
  - Pick the first set bit of the registered `pending`, scanning ptr, ptr+1, …, ptr+15, all mod 16.
  - Call the result `sel`.
- On load:
  - `out_idx` ← `sel`.
  - `out_multi` ← (popcount(`pending`) ≥ 2).
  - `ptr` ← `sel`+1 mod 16; 15 wraps to 0.
  - Bit `sel` is cleared from `pending`.
- Pending update: next `pending` = (`pending` & ~load_mask) | `req`, where load_mask is one-hot(`sel`) when load, else 0.
- A `req` bit equal to `sel` in the load cycle wins. The bit stays pending and is issued again later. Each assertion is a new event.
- Re-requesting a line whose index is currently held in the output stage sets its pending bit. That line is issued again after the current handshake.
- `clr`: next `pending` = `req`, next `out_valid` = 0, `ptr` unchanged. A held output is dropped without a handshake.
- `reset` overrides `clr`, `req` and `out_ready` in the same cycle.
- `req` bits already pending are absorbed: there is no counting, at most one outstanding issue per line.

## Timing
- Latency: `req` high at edge t → `pending` set after t → `out_valid` high after edge t+1. That is 2 cycles from request to valid output.
- Throughput: 1 index per cycle while `out_ready`=1 and `pending`≠0.
- Outputs are registered only; nothing combinational from `req` or `out_ready` reaches any output.
- Backpressure: `out_valid` never drops and `out_idx` never changes while `out_valid`=1 and `out_ready`=0. The only exceptions are `clr` and `reset`.
- `out_ready` while `out_valid`=0 is ignored.
- Reset mid-operation: all outputs read reset values in the cycle after the reset edge. Requests present during reset are discarded.

## Test plan
- Single request:
  - Stimulus: after reset, `req`=16'h0002 for 1 cycle, `out_ready`=1.
  - Required: `pending`=16'h0002 one cycle later. Next cycle `out_valid`=1, `out_idx`=1, `out_multi`=0. Then `out_valid`=0, `ptr`=2.
- Wrap:
  - Stimulus: from reset, `req`=16'h8001 for 1 cycle, `out_ready`=1.
  - Required: `out_idx`=0 with `out_multi`=1, then `out_idx`=15 with `out_multi`=0 on consecutive cycles. `ptr` ends at 0.
- Round-robin fairness:
  - Stimulus: with `ptr`=2, `req`=16'h0011 held high and `out_ready`=1.
  - Required: issue order is 4, 0, 4, 0, …. No line issues twice in a row while the other is pending.
- Backpressure:
  - Stimulus: `out_idx`=3 held with `out_ready`=0 for 5 cycles while `req`=16'h0028 pulses once.
  - Required: `out_idx` stays 3 and `out_valid` stays 1. `pending`=16'h0028. After `out_ready`=1, the output sequence is 3, 5, 3.
- clr mid-operation:
  - Stimulus: `out_valid`=1 and `pending`=16'h0F00; pulse `clr` with `req`=16'h0040.
  - Required: next cycle `out_valid`=0 and `pending`=16'h0040. One cycle later `out_idx`=6.
- Reset mid-operation:
  - Stimulus: `pending`=16'hFFFF, `out_valid`=1; assert `reset` with `req`=16'hFFFF.
  - Required: `pending`=0, `out_valid`=0, `out_idx`=0, `out_multi`=0, `ptr`=0.
